spi_adc_slave_tx: RTL and testbench
===================================

Name: spi_adc_slave_tx

Overview:
SPI slave transmitter that answers the SenseEdge ADC-side SPI master (CPOL=0, 16-bit frames, MSB first, master samples MISO on SCLK falling edge). It emulates an external 12-bit ADC: samples pushed over a valid/ready port are buffered in a small FIFO and returned one per chip-select frame. It is used as an on-chip loopback/self-test source and as the ADC model for system-level verification of the acquisition path.

Parameters:
DATA_BITS, 12, sample width carried in frame bits [11:0]
FRAME_BITS, 16, SCLK falling edges per frame
FIFO_DEPTH, 8, sample FIFO entries; must be a power of 2
UNDERRUN_WORD, 12'h800, sample value sent when the FIFO is empty at frame start

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  block enable; low flushes the FIFO and forces idle
spi_clk  in  1  SCLK from the master, asynchronous
spi_cs_n  in  1  chip select from the master, active low, asynchronous
spi_miso  out  1  serial data to the master, registered
spi_miso_oe  out  1  MISO output enable; high only while the synchronized CS is low
s_valid  in  1  sample push valid
s_data  in  DATA_BITS  sample to push
s_ready  out  1  high when the FIFO is not full
fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
frame_done  out  1  one-cycle pulse when a full frame has been shifted
underrun_cnt  out  8  saturating count of frames started with an empty FIFO
abort_cnt  out  8  saturating count of frames terminated early by CS high

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE; FIFO empty; seq=0; all counters 0; spi_miso=0; spi_miso_oe=0; frame_done=0; s_ready=1 once enable is high.
- spi_clk and spi_cs_n each pass through a 2-FF synchronizer. Edges are detected on the synchronized signals with one additional register. Requirement on the master: SCLK high and low phases, and the CS-fall-to-first-rise time, are each >= 4 clk.
- Frame word = {seq[3:0], sample[11:0]}. seq is a 4-bit counter that increments on every frame start, including underrun frames, and wraps 15->0.
- FSM states:
  - IDLE: MISO=0. On a detected CS fall with enable=1, go to LOAD.
  - LOAD (1 cycle): pop the FIFO if it is non-empty; otherwise use UNDERRUN_WORD and increment underrun_cnt. Load the shift register, drive bit 15 on MISO, set bit_cnt=0, go to SHIFT. MISO is therefore valid 2 clk after the synchronized CS fall.
  - SHIFT: on each synchronized SCLK fall, increment bit_cnt and shift left; MISO takes the next bit, with 0 shifted in. When bit_cnt reaches FRAME_BITS-1 on a fall, pulse frame_done and go to DONE.
  - DONE: MISO=0 regardless of any extra SCLK edges. On CS rise, go to IDLE.
- CS rise while in LOAD or SHIFT: increment abort_cnt, go to IDLE, MISO=0. The popped sample is discarded and not re-sent. frame_done does not pulse.
- SCLK edges while CS is high are ignored.
- FIFO:
  - A push happens on s_valid && s_ready; s_ready = !full.
  - No bypass: a push and a LOAD in the same cycle with an empty FIFO produce an underrun, and the pushed sample is stored.
  - A push and a pop in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- enable low: FIFO flushed, FSM forced to IDLE, MISO=0, oe=0, s_ready=0. A frame in progress counts as an abort. Counters and seq hold their values.
- Counters saturate at 255.

Test Plan:
- Push 12'h123, 12'hABC, then run 2 master frames with clk_div=3 -> master reads 16'h0123 and 16'h1ABC; frame_done pulses twice; fifo_level returns to 0.
- Frame started with an empty FIFO -> MISO word 16'h0800 (seq=0); underrun_cnt=1; a following push of 12'h005 and a frame -> 16'h1005.
- Push 9 samples with depth 8 -> s_ready low after the 8th push; the 9th sample is not accepted; fifo_level=8; a frame pops one entry and s_ready returns high.
- CS raised after 7 falling edges -> abort_cnt=1, no frame_done; the next frame sends the following FIFO sample with seq incremented.
- Assert rst_n low mid-SHIFT -> MISO=0, oe=0, fifo_level=0, counters=0 immediately, without waiting for a clock; the next frame sends seq=0.
- Run 17 frames through the master, driven in a loop, with samples 0..16 -> upper nibble sequence 0..15,0 is seen; the master's sign extension yields 16'hF800 for the value 12'h800.

Source files
------------

// File: rtl/spi_adc_slave_tx.sv
// SPI slave transmitter emulating a 12-bit ADC: buffered samples are returned one per CS frame
// as {seq, sample}, MSB first, shifted on synchronized SCLK falling edges.
module spi_adc_slave_tx #(
  parameter int unsigned          DATA_BITS     = 12,
  parameter int unsigned          FRAME_BITS    = 16,
  parameter int unsigned          FIFO_DEPTH    = 8,
  parameter logic [DATA_BITS-1:0] UNDERRUN_WORD = 12'h800
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            spi_clk,
  input  logic                            spi_cs_n,
  output logic                            spi_miso,
  output logic                            spi_miso_oe,
  input  logic                            s_valid,
  input  logic [DATA_BITS-1:0]            s_data,
  output logic                            s_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            frame_done,
  output logic [7:0]                      underrun_cnt,
  output logic [7:0]                      abort_cnt
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned SeqW  = FRAME_BITS - DATA_BITS;
  localparam int unsigned CntW  = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              sclk_sync_q, sclk_sync_d;
  logic [2:0]              cs_sync_q, cs_sync_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [CntW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SeqW-1:0]         seq_q, seq_d;
  logic [7:0]              under_q, under_d;
  logic [7:0]              abort_q, abort_d;
  logic                    miso_q, miso_d;
  logic                    frame_done_q, frame_done_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0]    mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]    mem_d [FIFO_DEPTH];

  logic                    sclk_fall, cs_fall, cs_rise, cs_sync;
  logic                    push, pop, fifo_empty, fifo_full;
  logic [PtrW-1:0]         level;
  logic [DATA_BITS-1:0]    sample;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Bit [1] is the synchronized level, bit [2] its one-cycle-old copy for edge detection.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], spi_clk};
    cs_sync_d   = {cs_sync_q[1:0], spi_cs_n};
  end

  assign cs_sync   = cs_sync_q[1];
  assign cs_fall   = cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise   = ~cs_sync_q[2] & cs_sync_q[1];
  assign sclk_fall = sclk_sync_q[2] & ~sclk_sync_q[1] & ~cs_sync;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (level == PtrW'(FIFO_DEPTH));
  assign push       = s_valid & s_ready;
  assign sample     = fifo_empty ? UNDERRUN_WORD : mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[AddrW-1:0]] = s_data;
    wr_ptr_d = enable ? wr_ptr_q + PtrW'(push) : '0;
    rd_ptr_d = enable ? rd_ptr_q + PtrW'(pop) : '0;
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    seq_d        = seq_q;
    under_d      = under_q;
    abort_d      = abort_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      if (state_q == StLoad || state_q == StShift) abort_d = sat_inc(abort_q);
    end else begin
      unique case (state_q)
        StIdle: if (cs_fall) state_d = StLoad;
        StLoad: begin
          // No bypass: an empty FIFO here means underrun even if a push lands this cycle.
          pop       = ~fifo_empty;
          seq_d     = seq_q + 1'b1;
          shift_d   = {seq_q, sample};
          bit_cnt_d = '0;
          if (fifo_empty) under_d = sat_inc(under_q);
          if (cs_rise) begin
            abort_d = sat_inc(abort_q);
            state_d = StIdle;
          end else begin
            state_d = StShift;
          end
        end
        StShift: begin
          if (cs_rise) begin
            abort_d = sat_inc(abort_q);
            state_d = StIdle;
          end else if (sclk_fall) begin
            if (bit_cnt_q == CntW'(FRAME_BITS - 1)) begin
              frame_done_d = 1'b1;
              state_d      = StDone;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              shift_d   = shift_q << 1;
            end
          end
        end
        StDone: if (cs_rise) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    miso_d = (state_d == StShift) ? shift_d[FRAME_BITS-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sclk_sync_q  <= 3'b000;
      cs_sync_q    <= 3'b111;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      seq_q        <= '0;
      under_q      <= '0;
      abort_q      <= '0;
      miso_q       <= 1'b0;
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      seq_q        <= seq_d;
      under_q      <= under_d;
      abort_q      <= abort_d;
      miso_q       <= miso_d;
      frame_done_q <= frame_done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
    end
  end

  assign spi_miso     = miso_q;
  assign spi_miso_oe  = enable & ~cs_sync;
  assign s_ready      = enable & ~fifo_full;
  assign fifo_level   = level;
  assign frame_done   = frame_done_q;
  assign underrun_cnt = under_q;
  assign abort_cnt    = abort_q;

endmodule

// File: tb/tb_spi_adc_slave_tx.sv
// Scoreboard bench: an SPI master task issues frames, a queue model predicts each word,
// and a monitor process compares received words against the predictions.
module tb_spi_adc_slave_tx;

  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        s_valid = 1'b0;
  logic [11:0] s_data = '0;
  logic        spi_miso, spi_miso_oe, s_ready, frame_done;
  logic [3:0]  fifo_level;
  logic [7:0]  underrun_cnt, abort_cnt;

  spi_adc_slave_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .spi_clk     (spi_clk),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .fifo_level  (fifo_level),
    .frame_done  (frame_done),
    .underrun_cnt(underrun_cnt),
    .abort_cnt   (abort_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: sample queue plus sequence and event counts.
  int          mdl_q[$];
  int          mdl_seq = 0;
  int          mdl_under = 0;
  int          mdl_abort = 0;
  int          mdl_done = 0;
  int          done_seen = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rx_q[$];

  always @(posedge clk) if (frame_done === 1'b1) done_seen++;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  function automatic logic [15:0] mdl_start();
    int smp;
    if (mdl_q.size() == 0) begin
      smp = 'h800;
      mdl_under = sat(mdl_under);
    end else begin
      smp = mdl_q.pop_front();
    end
    mdl_start = 16'((mdl_seq << 12) | smp);
    mdl_seq = (mdl_seq + 1) % 16;
  endfunction

  task automatic mdl_reset();
    mdl_q.delete();
    mdl_seq = 0;
    mdl_under = 0;
    mdl_abort = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    spi_cs_n = 1'b1;
    spi_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    mdl_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic push(input int x);
    int exp_rdy;
    @(negedge clk);
    exp_rdy = (enable && mdl_q.size() < Depth) ? 1 : 0;
    chk("s_ready_at_push", s_ready, exp_rdy);
    s_valid = 1'b1;
    s_data = 12'(x);
    @(negedge clk);
    s_valid = 1'b0;
    if (exp_rdy != 0) mdl_q.push_back(x & 'hFFF);
    chk("fifo_level_after_push", fifo_level, mdl_q.size());
  endtask

  // Master: one SCLK phase is div+1 clk; MISO sampled at each falling edge.
  task automatic do_frame(input int div, input int nfalls, input bit raise,
                          output logic [15:0] w);
    logic [15:0] e;
    w = '0;
    e = mdl_start();
    if (nfalls == 16) exp_q.push_back(e);
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (div + 1) @(negedge clk);
    for (int i = 0; i < nfalls; i++) begin
      spi_clk = 1'b1;
      repeat (div + 1) @(negedge clk);
      w = {w[14:0], spi_miso};
      spi_clk = 1'b0;
      repeat (div + 1) @(negedge clk);
    end
    if (nfalls == 16) begin
      rx_q.push_back(w);
      mdl_done++;
    end else if (raise) begin
      mdl_abort = sat(mdl_abort);
    end
    if (raise) begin
      spi_cs_n = 1'b1;
      repeat (div + 4) @(negedge clk);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_level"}, fifo_level, mdl_q.size());
    chk({tag, "_underrun"}, underrun_cnt, mdl_under);
    chk({tag, "_abort"}, abort_cnt, mdl_abort);
    chk({tag, "_frame_done"}, done_seen, mdl_done);
  endtask

  // Monitor: compares each completed master word with the oldest prediction.
  initial begin
    logic [15:0] r;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      while (rx_q.size() > 0) begin
        r = rx_q.pop_front();
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL frame_word: got 0x%0h, expected no frame", r);
        end else begin
          e = exp_q.pop_front();
          chk("frame_word", r, e);
        end
      end
    end
  end

  initial begin
    logic [15:0] w;
    int          op;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_miso", spi_miso, 0);
    chk("rst_oe", spi_miso_oe, 0);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    check_status("rst");

    // Two buffered samples
    push('h123);
    push('hABC);
    do_frame(3, 16, 1, w);
    do_frame(3, 16, 1, w);
    check_status("two_frames");

    // Underrun then a pushed sample
    apply_reset();
    do_frame(3, 16, 1, w);
    chk("underrun_word", w, 16'h0800);
    push('h005);
    do_frame(3, 16, 1, w);
    chk("post_underrun_word", w, 16'h1005);
    check_status("underrun");

    // Fill past depth
    apply_reset();
    for (int i = 0; i < 9; i++) push(16 + i);
    chk("full_level", fifo_level, 8);
    chk("full_s_ready", s_ready, 0);
    do_frame(4, 16, 1, w);
    chk("unfull_s_ready", s_ready, 1);
    check_status("full");

    // Abort after 7 falls, then a normal frame
    do_frame(3, 7, 1, w);
    check_status("abort");
    do_frame(3, 16, 1, w);
    check_status("after_abort");

    // Asynchronous reset mid-SHIFT
    do_frame(3, 5, 0, w);
    rst_n = 1'b0;
    #1;
    chk("arst_miso", spi_miso, 0);
    chk("arst_oe", spi_miso_oe, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_underrun", underrun_cnt, 0);
    chk("arst_abort", abort_cnt, 0);
    spi_cs_n = 1'b1;
    spi_clk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
    repeat (2) @(negedge clk);
    push('h3C5);
    do_frame(3, 16, 1, w);
    chk("post_arst_word", w, 16'h03C5);

    // Seventeen frames: sequence wraps
    apply_reset();
    for (int i = 0; i <= 16; i++) begin
      push(i);
      do_frame(3, 16, 1, w);
      chk("seq_nibble", w[15:12], i % 16);
    end
    do_frame(3, 16, 1, w);
    chk("sign_ext_underrun", {{4{w[11]}}, w[11:0]}, 16'hF800);
    check_status("seq_wrap");

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 19);
      if (op < 8) begin
        for (int k = $urandom_range(1, 4); k > 0; k--) push($urandom_range(0, 4095));
      end else if (op < 17) begin
        do_frame($urandom_range(3, 6), 16, 1, w);
      end else if (op < 19) begin
        do_frame($urandom_range(3, 6), $urandom_range(1, 15), 1, w);
      end else begin
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("disable_s_ready", s_ready, 0);
        chk("disable_level", fifo_level, 0);
        mdl_q.delete();
        enable = 1'b1;
        @(negedge clk);
      end
    end
    repeat (10) @(negedge clk);
    check_status("random");

    for (int i = 0; i < 50 && rx_q.size() > 0; i++) @(negedge clk);
    chk("rx_drained", rx_q.size(), 0);
    chk("exp_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
